cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the cpu core: pulses the core reset, supervises execution, captures halt PC or watchdog abort.
// Latency: cpu_rst_n low for RST_CYCLES cycles from the start edge; halt/timeout reflected on the edge that detects it.
// Backpressure: none; start is a single-cycle request honoured only in IDLE/HALTED/TOUT. Optional: `define PC_STALL_EN.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 65535,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hlt,
    input  logic [15:0]      pc,
    output logic             cpu_rst_n,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      halt_pc,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_RUN    = 3'd2,
        S_HALTED = 3'd3,
        S_TOUT   = 3'd4
    } state_t;

    // Reset counter only needs to hold RST_CYCLES-1.
    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit               WD_EN   = (TIMEOUT != 0);

    state_t            state, state_d;
    logic [RC_W-1:0]   rcnt, rcnt_d;
    logic              cpu_rst_n_d;
    logic              done_d;
    logic              timeout_d;
    logic [15:0]       halt_pc_d;
    logic [CNT_W-1:0]  cycle_cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              wd_hit;

`ifdef PC_STALL_EN
    // Stall detection: counts consecutive RUN cycles (including the current one) with an unchanged pc.
    localparam logic [8:0] STALL_LIMIT = 9'd256;
    logic [8:0]  stall_cnt, stall_cnt_d;
    logic [8:0]  stall_next;
    logic [15:0] last_pc, last_pc_d;
`endif

    // Saturating increment and watchdog compare, shared by the RUN branch.
    always_comb begin
        cnt_inc = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_W'(1);
        wd_hit  = WD_EN && (cycle_cnt != CNT_MAX) && (cnt_inc == TMO_VAL);
    end

    // Next-state and next-output logic; every registered output is computed here and flopped below.
    always_comb begin
        state_d     = state;
        rcnt_d      = rcnt;
        cpu_rst_n_d = cpu_rst_n;
        done_d      = done;
        timeout_d   = timeout;
        halt_pc_d   = halt_pc;
        cycle_cnt_d = cycle_cnt;
`ifdef PC_STALL_EN
        stall_cnt_d = stall_cnt;
        last_pc_d   = last_pc;
        stall_next  = ((stall_cnt != 9'd0) && (pc == last_pc)) ? stall_cnt + 9'd1 : 9'd1;
`endif

        case (state)
            S_IDLE, S_HALTED, S_TOUT: begin
                // HALTED keeps the core out of reset so it stays frozen on its own halt.
                cpu_rst_n_d = (state == S_HALTED);
                if (start) begin
                    state_d     = S_RESET;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    cycle_cnt_d = '0;
                    halt_pc_d   = 16'h0000;
                    rcnt_d      = RC_LOAD;
                end
            end

            S_RESET: begin
                cpu_rst_n_d = 1'b0;
                if (rcnt == '0) begin
                    state_d     = S_RUN;
                    cpu_rst_n_d = 1'b1;
`ifdef PC_STALL_EN
                    stall_cnt_d = 9'd0;
`endif
                end else begin
                    rcnt_d = rcnt - RC_W'(1);
                end
            end

            S_RUN: begin
                cpu_rst_n_d = 1'b1;
                if (hlt) begin
                    // Halt takes priority over any abort condition in the same cycle.
                    state_d   = S_HALTED;
                    done_d    = 1'b1;
                    halt_pc_d = pc;
                end else begin
                    cycle_cnt_d = cnt_inc;
                    if (wd_hit) begin
                        state_d     = S_TOUT;
                        timeout_d   = 1'b1;
                        cpu_rst_n_d = 1'b0;
                    end
`ifdef PC_STALL_EN
                    stall_cnt_d = stall_next;
                    last_pc_d   = pc;
                    if (stall_next == STALL_LIMIT) begin
                        state_d     = S_TOUT;
                        timeout_d   = 1'b1;
                        cpu_rst_n_d = 1'b0;
                        halt_pc_d   = pc;
                    end
`endif
                end
            end

            default: begin
                state_d     = S_IDLE;
                cpu_rst_n_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset forces the core into reset immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rcnt      <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            halt_pc   <= 16'h0000;
            cycle_cnt <= '0;
`ifdef PC_STALL_EN
            stall_cnt <= 9'd0;
            last_pc   <= 16'h0000;
`endif
        end else begin
            state     <= state_d;
            rcnt      <= rcnt_d;
            cpu_rst_n <= cpu_rst_n_d;
            done      <= done_d;
            timeout   <= timeout_d;
            halt_pc   <= halt_pc_d;
            cycle_cnt <= cycle_cnt_d;
`ifdef PC_STALL_EN
            stall_cnt <= stall_cnt_d;
            last_pc   <= last_pc_d;
`endif
        end
    end

    // Busy is decoded from the registered state so it drops with the async reset.
    always_comb begin
        busy = (state == S_RESET) || (state == S_RUN);
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: drives a simple core model (hlt/pc) and checks run results through a scoreboard.
// Latency: expectations pushed when a run is launched, popped when busy falls.
// Backpressure: n/a; every wait is bounded by a cycle budget.
module tb_cpu_run_ctrl;

`ifdef PC_STALL_EN
    localparam int TMO  = 1000;
`else
    localparam int TMO  = 20;
`endif
    localparam int RSTC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hlt;
    logic [15:0] pc;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] halt_pc;
    logic [31:0] cycle_cnt;

    typedef struct packed {
        logic        done;
        logic        tout;
        logic [15:0] hpc;
        logic [31:0] cnt;
        logic        crn;
    } res_t;

    res_t exp_q[$];
    int   tests_run = 0;
    int   fails     = 0;

    cpu_run_ctrl #(
        .RST_CYCLES (RSTC),
        .TIMEOUT    (TMO),
        .CNT_W      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hlt       (hlt),
        .pc        (pc),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .halt_pc   (halt_pc),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, check that results are cleared and cpu_rst_n is low exactly RSTC cycles.
    task automatic start_run(input string tag);
        int low;
        low   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({busy, done, timeout, halt_pc, cycle_cnt} !== {1'b1, 1'b0, 1'b0, 16'h0000, 32'd0}) begin
            fails++;
            $display("FAIL %s_start_clear: busy/done/tout/hpc/cnt got %b/%b/%b/%h/%0d want 1/0/0/0000/0",
                     tag, busy, done, timeout, halt_pc, cycle_cnt);
        end
        while (cpu_rst_n !== 1'b1 && low < 50) begin
            low++;
            tick();
        end
        tests_run++;
        if (low != RSTC || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_rst_pulse: low cycles %0d busy %b want %0d busy 1", tag, low, busy, RSTC);
        end
    endtask

    // Core model for one run; pc walks unless held, hlt fires on RUN cycle hlt_at (0 = never).
    task automatic drive_run(input string tag, input int hlt_at, input bit hold_pc,
                             input logic [15:0] hpc, input int start_at);
        int   k;
        res_t e;
        res_t o;
        k = 1;
        while (busy === 1'b1 && k <= 2000) begin
            hlt   = (k == hlt_at);
            pc    = (hold_pc || k == hlt_at) ? hpc : 16'h1000 + 16'(k);
            start = (k == start_at);
            tick();
            start = 1'b0;
            if (k == start_at) begin
                tests_run++;
                if (cpu_rst_n !== 1'b1 || busy !== 1'b1 || cycle_cnt !== 32'(k)) begin
                    fails++;
                    $display("FAIL %s_start_ignored: crn %b busy %b cnt %0d want 1 1 %0d",
                             tag, cpu_rst_n, busy, cycle_cnt, k);
                end
            end
            k++;
        end
        hlt = 1'b0;
        if (busy === 1'b1) begin
            tests_run++;
            fails++;
            $display("FAIL %s_run_bound: busy still 1 after %0d cycles, want 0", tag, k);
        end
        tests_run++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s_sb_empty: no expectation queued, want 1", tag);
        end else begin
            e      = exp_q.pop_front();
            o.done = done;
            o.tout = timeout;
            o.hpc  = halt_pc;
            o.cnt  = cycle_cnt;
            o.crn  = cpu_rst_n;
            if (o !== e) begin
                fails++;
                $display("FAIL %s_result: done/tout/hpc/cnt/crn got %b/%b/%h/%0d/%b want %b/%b/%h/%0d/%b",
                         tag, o.done, o.tout, o.hpc, o.cnt, o.crn, e.done, e.tout, e.hpc, e.cnt, e.crn);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        hlt   = 1'b0;
        pc    = 16'h0000;
        #1;
        tests_run++;
        if ({cpu_rst_n, busy, done, timeout, halt_pc, cycle_cnt} !== {4'b0000, 16'h0000, 32'd0}) begin
            fails++;
            $display("FAIL reset_state: crn/busy/done/tout/hpc/cnt got %b/%b/%b/%b/%h/%0d want all 0",
                     cpu_rst_n, busy, done, timeout, halt_pc, cycle_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (cpu_rst_n !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: crn %b busy %b want 0 0", cpu_rst_n, busy);
        end
    endtask

    task automatic test_halt();
        exp_q.push_back({1'b1, 1'b0, 16'h0042, 32'd9, 1'b1});
        start_run("halt");
        drive_run("halt", 10, 1'b0, 16'h0042, 0);
        pc = 16'h5555;
        tick();
        tick();
        tick();
        tests_run++;
        if ({done, halt_pc, cycle_cnt, cpu_rst_n, busy} !== {1'b1, 16'h0042, 32'd9, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL halted_hold: done/hpc/cnt/crn/busy got %b/%h/%0d/%b/%b want 1/0042/9/1/0",
                     done, halt_pc, cycle_cnt, cpu_rst_n, busy);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back({1'b0, 1'b1, 16'h0000, 32'(TMO), 1'b0});
        start_run("tout");
        drive_run("tout", 0, 1'b0, 16'h0000, 0);
        tick();
        tick();
        tests_run++;
        if ({timeout, done, cpu_rst_n, busy} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL tout_hold: tout/done/crn/busy got %b/%b/%b/%b want 1/0/0/0",
                     timeout, done, cpu_rst_n, busy);
        end
    endtask

    task automatic test_hlt_vs_timeout();
        exp_q.push_back({1'b1, 1'b0, 16'h0055, 32'(TMO - 1), 1'b1});
        start_run("race");
        drive_run("race", TMO, 1'b0, 16'h0055, 0);
    endtask

    task automatic test_start_ignored();
        exp_q.push_back({1'b1, 1'b0, 16'h0077, 32'd7, 1'b1});
        start_run("ign");
        drive_run("ign", 8, 1'b0, 16'h0077, 3);
    endtask

    task automatic test_restart_stale();
        exp_q.push_back({1'b1, 1'b0, 16'h0099, 32'd4, 1'b1});
        hlt = 1'b1;
        start_run("stale");
        drive_run("stale", 5, 1'b0, 16'h0099, 0);
    endtask

`ifdef PC_STALL_EN
    task automatic test_stall();
        exp_q.push_back({1'b0, 1'b1, 16'h0010, 32'd256, 1'b0});
        start_run("stall");
        drive_run("stall", 0, 1'b1, 16'h0010, 0);
    endtask
`endif

    task automatic test_async_reset();
        start_run("arst");
        for (int i = 0; i < 5; i++) begin
            hlt = 1'b0;
            pc  = 16'h2000 + 16'(i);
            tick();
        end
        tests_run++;
        if (cpu_rst_n !== 1'b1 || cycle_cnt !== 32'd5) begin
            fails++;
            $display("FAIL arst_pre: crn %b cnt %0d want 1 5", cpu_rst_n, cycle_cnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cpu_rst_n, busy, done, timeout, halt_pc, cycle_cnt} !== {4'b0000, 16'h0000, 32'd0}) begin
            fails++;
            $display("FAIL arst_mid_run: crn/busy/done/tout/hpc/cnt got %b/%b/%b/%b/%h/%0d want all 0",
                     cpu_rst_n, busy, done, timeout, halt_pc, cycle_cnt);
        end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_halt();
        test_timeout();
        test_hlt_vs_timeout();
        test_start_ignored();
        test_restart_stale();
`ifdef PC_STALL_EN
        test_stall();
`endif
        test_async_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
